mesm6_alu_ctl: RTL and testbench

Sequencer and arbiter for the shared mesm6 combinational ALU.
- Two requesters share the ALU: the execution unit (port 0) and the address/fetch unit (port 1). Each presents a command with a valid/ready handshake.
- Single-cycle ALU ops are issued, and the controller waits for the ALU's `done` signal.
- MUL is sequenced as 48 shift-add iterations that reuse the ALU adder. The 96-bit product is returned on `rsp_r` (high half) and `rsp_y` (low half).
- Sits between the decode/fetch logic and the mesm6_alu instance.

---
 rtl/mesm6_alu_ctl_pkg.sv | 26 ++
 rtl/mesm6_alu_ctl_if.sv | 49 ++++
 rtl/mesm6_alu_rr_arb.sv | 30 +++
 rtl/mesm6_alu_ctl.sv | 144 ++++++++++++++
 tb/tb_mesm6_alu_ctl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mesm6_alu_ctl_pkg.sv
// Shared definitions for the mesm6 ALU controller: op codes, word width and FSM state encodings.
package mesm6_alu_ctl_pkg;

    localparam int ALU_CTL_W    = 48;
    localparam int ALU_OP_WIDTH = 4;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_NOP = 4'd0;
    localparam alu_op_t ALU_ADD = 4'd1;
    localparam alu_op_t ALU_SUB = 4'd2;
    localparam alu_op_t ALU_AND = 4'd3;
    localparam alu_op_t ALU_OR  = 4'd4;
    localparam alu_op_t ALU_XOR = 4'd5;
    localparam alu_op_t ALU_NOT = 4'd6;
    localparam alu_op_t ALU_SHL = 4'd7;
    localparam alu_op_t ALU_SHR = 4'd8;

    typedef enum logic [1:0] {
        ALU_CTL_IDLE = 2'd0,
        ALU_CTL_EXEC = 2'd1,
        ALU_CTL_MUL  = 2'd2,
        ALU_CTL_RESP = 2'd3
    } alu_ctl_state_e;

endpackage

// File: rtl/mesm6_alu_ctl_if.sv
// Request, response and ALU-side signals of the mesm6 ALU controller.
interface mesm6_alu_ctl_if #(parameter int WIDTH = 48);

    logic                                       req0_valid;
    logic                                       req0_ready;
    logic [mesm6_alu_ctl_pkg::ALU_OP_WIDTH-1:0] req0_op;
    logic                                       req0_mul;
    logic [WIDTH-1:0]                           req0_a;
    logic [WIDTH-1:0]                           req0_b;

    logic                                       req1_valid;
    logic                                       req1_ready;
    logic [mesm6_alu_ctl_pkg::ALU_OP_WIDTH-1:0] req1_op;
    logic                                       req1_mul;
    logic [WIDTH-1:0]                           req1_a;
    logic [WIDTH-1:0]                           req1_b;

    logic                                       rsp_valid;
    logic                                       rsp_id;
    logic [WIDTH-1:0]                           rsp_r;
    logic [WIDTH-1:0]                           rsp_y;

    logic [WIDTH-1:0]                           alu_a;
    logic [WIDTH-1:0]                           alu_b;
    logic [mesm6_alu_ctl_pkg::ALU_OP_WIDTH-1:0] alu_op;
    logic [WIDTH-1:0]                           alu_r;
    logic                                       alu_done;

    // Controller side.
    modport slave (
        input  req0_valid, req0_op, req0_mul, req0_a, req0_b,
        input  req1_valid, req1_op, req1_mul, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_y,
        output alu_a, alu_b, alu_op,
        input  alu_r, alu_done
    );

    // Requesters plus the ALU itself.
    modport master (
        output req0_valid, req0_op, req0_mul, req0_a, req0_b,
        output req1_valid, req1_op, req1_mul, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_y,
        input  alu_a, alu_b, alu_op,
        output alu_r, alu_done
    );

endinterface

// File: rtl/mesm6_alu_rr_arb.sv
// Two-way round-robin arbiter; last_grant resets to 1 so port 0 wins the first tie.
module mesm6_alu_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic r_last;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            gnt[0] = req[0] & (~req[1] | r_last);
            gnt[1] = req[1] & (~req[0] | ~r_last);
        end
    end

    assign gnt_id = gnt[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last <= 1'b1;
        else if (|gnt)
            r_last <= gnt_id;
    end

endmodule

// File: rtl/mesm6_alu_ctl.sv
// Arbitrates two requesters onto the shared mesm6 ALU; MUL runs as WIDTH shift-add steps through the ALU adder.
module mesm6_alu_ctl
    import mesm6_alu_ctl_pkg::*;
#(
    parameter int WIDTH = ALU_CTL_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    mesm6_alu_ctl_if.slave   bus
);

    alu_ctl_state_e   r_state;
    logic             r_id;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    alu_op_t          r_alu_op;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_r;
    logic [WIDTH-1:0] r_rsp_y;

    logic [1:0]       w_gnt;
    logic             w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    alu_op_t          w_op;
    logic             w_mul;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    mesm6_alu_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({bus.req1_valid, bus.req0_valid}),
        .enable  (r_state == ALU_CTL_IDLE),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id)
    );

    assign w_accept       = |w_gnt;
    assign bus.req0_ready = w_gnt[0];
    assign bus.req1_ready = w_gnt[1];

    assign w_a   = w_gnt_id ? bus.req1_a   : bus.req0_a;
    assign w_b   = w_gnt_id ? bus.req1_b   : bus.req0_b;
    assign w_op  = w_gnt_id ? bus.req1_op  : bus.req0_op;
    assign w_mul = w_gnt_id ? bus.req1_mul : bus.req0_mul;

    // During MUL the ALU operand registers double as the product accumulator:
    // r_alu_a is the high half, r_alu_b the multiplicand, r_lo the low half/multiplier.
    assign w_carry = (bus.alu_r < r_alu_a);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        if (r_lo[0]) begin
            w_hi_nxt = {w_carry, bus.alu_r[WIDTH-1:1]};
            w_lo_nxt = {bus.alu_r[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nxt = {1'b0, r_alu_a[WIDTH-1:1]};
            w_lo_nxt = {r_alu_a[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ALU_CTL_IDLE;
            r_id        <= 1'b0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= ALU_NOP;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_r     <= '0;
            r_rsp_y     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ALU_CTL_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_gnt_id;
                        r_lo  <= w_b;
                        r_cnt <= '0;
                        if (w_mul) begin
                            r_alu_a  <= '0;
                            r_alu_b  <= w_a;
                            r_alu_op <= ALU_ADD;
                            r_state  <= ALU_CTL_MUL;
                        end else begin
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_alu_op <= w_op;
                            r_state  <= ALU_CTL_EXEC;
                        end
                    end
                end
                ALU_CTL_EXEC: begin
                    if (bus.alu_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_r     <= bus.alu_r;
                        r_rsp_y     <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_op    <= ALU_NOP;
                        r_state     <= ALU_CTL_RESP;
                    end
                end
                ALU_CTL_MUL: begin
                    r_alu_a <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_r     <= w_hi_nxt;
                        r_rsp_y     <= w_lo_nxt;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_op    <= ALU_NOP;
                        r_state     <= ALU_CTL_RESP;
                    end
                end
                default: r_state <= ALU_CTL_IDLE;
            endcase
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_r     = r_rsp_r;
    assign bus.rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// Directed bench for mesm6_alu_ctl with a small behavioural ALU in place of mesm6_alu.
module tb_mesm6_alu_ctl;
    import mesm6_alu_ctl_pkg::*;

    localparam int W = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mesm6_alu_ctl_if #(.WIDTH(W)) bus ();

    mesm6_alu_ctl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            ALU_ADD: bus.alu_r = bus.alu_a + bus.alu_b;
            ALU_AND: bus.alu_r = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_r = bus.alu_a | bus.alu_b;
            ALU_NOT: bus.alu_r = ~bus.alu_a;
            default: bus.alu_r = '0;
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 1'b0; bus.req0_op = ALU_NOP; bus.req0_mul = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = ALU_NOP; bus.req1_mul = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.alu_done = 1'b1;
        reset_n = 1'b0;
        step();
        step();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_r !== '0) begin n_err++; $display("FAIL reset_rsp_r got %h want 0", bus.rsp_r); end
        n_vec++; if (bus.rsp_y !== '0) begin n_err++; $display("FAIL reset_rsp_y got %h want 0", bus.rsp_y); end
        n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got %0h want 0", bus.rsp_id); end
        n_vec++; if (bus.alu_op !== ALU_NOP) begin n_err++; $display("FAIL reset_alu_op got %0h want %0h", bus.alu_op, ALU_NOP); end
        n_vec++; if (bus.alu_a !== '0 || bus.alu_b !== '0) begin n_err++; $display("FAIL reset_alu_ab got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
        n_vec++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b%0b want 00", bus.req1_ready, bus.req0_ready); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_and;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int k;
        a = 48'hF0F0_F0F0_F0F0;
        b = 48'hFF00_FF00_FF00;
        bus.alu_done = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = ALU_AND; bus.req0_mul = 1'b0; bus.req0_a = a; bus.req0_b = b;
        #1;
        n_vec++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL and_ready got %0b%0b want 01", bus.req1_ready, bus.req0_ready); end
        step();
        bus.req0_valid = 1'b0;
        n_vec++; if (bus.alu_op !== ALU_AND || bus.alu_a !== a || bus.alu_b !== b) begin n_err++; $display("FAIL and_alu_drive got op=%0h a=%h b=%h want op=%0h a=%h b=%h", bus.alu_op, bus.alu_a, bus.alu_b, ALU_AND, a, b); end
        k = 1;
        while (bus.rsp_valid !== 1'b1 && k < 200) begin step(); k++; end
        n_vec++; if (k != 2) begin n_err++; $display("FAIL and_latency got %0d want 2", k); end
        n_vec++; if (bus.rsp_r !== 48'hF000_F000_F000) begin n_err++; $display("FAIL and_rsp_r got %h want f000f000f000", bus.rsp_r); end
        n_vec++; if (bus.rsp_y !== '0) begin n_err++; $display("FAIL and_rsp_y got %h want 0", bus.rsp_y); end
        n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL and_rsp_id got %0h want 0", bus.rsp_id); end
        step();
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.rsp_r !== 48'hF000_F000_F000) begin n_err++; $display("FAIL and_rsp_hold got v=%0b r=%h want v=0 r=f000f000f000", bus.rsp_valid, bus.rsp_r); end
    endtask

    task automatic test_mul(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int k;
        int bad_op;
        bad_op = 0;
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_op = ALU_NOP; bus.req1_mul = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = ALU_NOP; bus.req0_mul = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        n_vec++; if ({bus.req1_ready, bus.req0_ready} !== (port ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL mul_ready got %0b%0b port %0d", bus.req1_ready, bus.req0_ready, port); end
        step();
        idle_inputs();
        k = 1;
        while (bus.rsp_valid !== 1'b1 && k < 200) begin
            if (bus.alu_op !== ALU_ADD) bad_op++;
            step();
            k++;
        end
        n_vec++; if (k != 49) begin n_err++; $display("FAIL mul_latency got %0d want 49", k); end
        n_vec++; if (bad_op != 0) begin n_err++; $display("FAIL mul_alu_op got %0d non-ADD cycles want 0", bad_op); end
        n_vec++; if (bus.rsp_r !== ehi) begin n_err++; $display("FAIL mul_rsp_r got %h want %h", bus.rsp_r, ehi); end
        n_vec++; if (bus.rsp_y !== elo) begin n_err++; $display("FAIL mul_rsp_y got %h want %h", bus.rsp_y, elo); end
        n_vec++; if (bus.rsp_id !== port) begin n_err++; $display("FAIL mul_rsp_id got %0h want %0h", bus.rsp_id, port); end
        step();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_r [2];
        int gid [4];
        int gcyc [4];
        int rid [4];
        logic [W-1:0] rr [4];
        int nr, ng, both, cyc;
        nr = 0; ng = 0; both = 0; cyc = 0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        exp_r[0] = 48'h00FF_0000_FF00 | 48'h0F00_0F00_000F;
        exp_r[1] = 48'h0000_0000_0111 | 48'h0000_0000_0222;
        bus.req0_valid = 1'b1; bus.req0_op = ALU_OR; bus.req0_mul = 1'b0; bus.req0_a = 48'h00FF_0000_FF00; bus.req0_b = 48'h0F00_0F00_000F;
        bus.req1_valid = 1'b1; bus.req1_op = ALU_OR; bus.req1_mul = 1'b0; bus.req1_a = 48'h0000_0000_0111; bus.req1_b = 48'h0000_0000_0222;
        while (nr < 4 && cyc < 60) begin
            #1;
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both++;
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
                if (ng < 4) begin gid[ng] = int'(bus.req1_ready); gcyc[ng] = cyc; end
                ng++;
            end
            if (bus.rsp_valid === 1'b1) begin rid[nr] = int'(bus.rsp_id); rr[nr] = bus.rsp_r; nr++; end
            if (nr < 4) begin step(); cyc++; end
        end
        idle_inputs();
        step();
        n_vec++; if (nr != 4 || ng != 4) begin n_err++; $display("FAIL b2b_counts got rsp=%0d grants=%0d want 4/4", nr, ng); end
        n_vec++; if (both != 0) begin n_err++; $display("FAIL b2b_dual_ready got %0d want 0", both); end
        if (nr == 4 && ng == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (gid[i] != i % 2) begin n_err++; $display("FAIL b2b_grant%0d got %0d want %0d", i, gid[i], i % 2); end
                n_vec++; if (rid[i] != i % 2) begin n_err++; $display("FAIL b2b_rsp_id%0d got %0d want %0d", i, rid[i], i % 2); end
                n_vec++; if (rr[i] !== exp_r[i % 2]) begin n_err++; $display("FAIL b2b_rsp_r%0d got %h want %h", i, rr[i], exp_r[i % 2]); end
                if (i > 0) begin
                    n_vec++; if (gcyc[i] - gcyc[i-1] != 3) begin n_err++; $display("FAIL b2b_interval%0d got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] a;
        a = 48'h1234_5678_9ABC;
        bus.alu_done = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = ALU_NOT; bus.req1_mul = 1'b0; bus.req1_a = a; bus.req1_b = 48'h5;
        step();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            n_vec++; if (bus.alu_op !== ALU_NOT || bus.alu_a !== a || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d got op=%0h a=%h v=%0b want op=%0h a=%h v=0", k, bus.alu_op, bus.alu_a, bus.rsp_valid, ALU_NOT, a); end
            step();
        end
        bus.alu_done = 1'b1;
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.alu_a !== a) begin n_err++; $display("FAIL stall_n4 got v=%0b a=%h want v=0 a=%h", bus.rsp_valid, bus.alu_a, a); end
        step();
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_latency got v=%0b at N+5 want 1", bus.rsp_valid); end
        n_vec++; if (bus.rsp_r !== 48'hEDCB_A987_6543 || bus.rsp_id !== 1'b1) begin n_err++; $display("FAIL stall_rsp got r=%h id=%0h want r=edcba9876543 id=1", bus.rsp_r, bus.rsp_id); end
        step();
    endtask

    task automatic test_reset_mid_mul;
        int spur;
        spur = 0;
        bus.alu_done = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_mul = 1'b1; bus.req0_a = 48'hFFFF_FFFF_FFFF; bus.req0_b = 48'hFFFF_FFFF_FFFF;
        step();
        idle_inputs();
        repeat (20) step();
        n_vec++; if (bus.alu_op !== ALU_ADD || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_pre got op=%0h v=%0b want op=%0h v=0", bus.alu_op, bus.rsp_valid, ALU_ADD); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus.alu_op !== ALU_NOP || bus.alu_a !== '0 || bus.alu_b !== '0) begin n_err++; $display("FAIL abort_alu got op=%0h a=%h b=%h want 0/0/0", bus.alu_op, bus.alu_a, bus.alu_b); end
        n_vec++; if (bus.rsp_r !== '0 || bus.rsp_y !== '0 || bus.rsp_id !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_rsp got r=%h y=%h id=%0h v=%0b want zeros", bus.rsp_r, bus.rsp_y, bus.rsp_id, bus.rsp_valid); end
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (bus.rsp_valid !== 1'b0) spur++;
            step();
        end
        n_vec++; if (spur != 0) begin n_err++; $display("FAIL abort_spurious_rsp got %0d want 0", spur); end
    endtask

    initial begin
        idle_inputs();
        bus.alu_done = 1'b1;
        test_reset();
        test_and();
        test_mul(1'b1, 48'd3, 48'd5, 48'd0, 48'd15);
        test_mul(1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFE, 48'h0000_0000_0001);
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        test_mul(1'b0, 48'd7, 48'd6, 48'd0, 48'd42);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
